// File: rtl/divn_restoring_if.sv
// Start/done handshake bundle for divn_restoring.
// The controller uses the master modport and the divider uses the slave modport.
// WIDTH must match the WIDTH of the divider instance the bundle is connected to.
interface divn_restoring_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sgn;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic [WIDTH-1:0] qut;
   logic [WIDTH-1:0] rmd;
   logic             busy;
   logic             done;
   logic             dbz;

   modport master (
      output start, sgn, src1, src2,
      input  qut, rmd, busy, done, dbz
   );

   modport slave (
      input  start, sgn, src1, src2,
      output qut, rmd, busy, done, dbz
   );
endinterface

// File: rtl/divn_restoring.sv
// Multi-cycle restoring divider. Each CALC cycle retires SPC quotient bits.
// The divider signals divide-by-zero with an explicit flag.
// Signed operation (sgn=1) is built only when DIVN_SIGNED_EN is defined.
// Without that macro every operation is unsigned and no sign logic exists.
module divn_restoring #(
   parameter int WIDTH = 32,
   parameter int SPC   = 1
) (
   input logic              clk,
   input logic              rst,
   divn_restoring_if.slave  bus
);
   localparam int STEPS = WIDTH / SPC;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor (magnitude in signed mode)
   logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
   logic [WIDTH-1:0] qut_q, qut_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dbz_q, dbz_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] step_rem, step_dvd;
   logic [WIDTH:0]   sh;
   logic [WIDTH+1:0] trial;
   logic             qbit;

`ifdef DIVN_SIGNED_EN
   logic qneg_q, qneg_d;   // quotient must be negated in FIX
   logic rneg_q, rneg_d;   // remainder must be negated in FIX (dividend sign)
   logic neg1, neg2;
   assign neg1 = bus.sgn & bus.src1[WIDTH-1];
   assign neg2 = bus.sgn & bus.src2[WIDTH-1];
`else
   logic unused_sgn;
   assign unused_sgn = bus.sgn;
`endif

   // Trial-subtract bit WIDTH is only a carry stage; a kept result is always below the divisor.
   logic unused_trial_bit;
   assign unused_trial_bit = trial[WIDTH];

   // Run SPC restoring steps on the current partial remainder and dividend.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      step_rem = rem_q;
      step_dvd = dvd_q;
      sh       = '0;
      trial    = '0;
      qbit     = 1'b0;
      for (int k = 0; k < SPC; k++) begin
         sh       = {step_rem, step_dvd[WIDTH-1]};
         trial    = {1'b0, sh} - {2'b00, dvs_q};
         qbit     = ~trial[WIDTH+1];
         step_rem = qbit ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
         step_dvd = {step_dvd[WIDTH-2:0], qbit};
      end
   end

   // Compute the next state and datapath loads.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      qut_d   = qut_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      cnt_d   = cnt_q;
`ifdef DIVN_SIGNED_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               dvd_d   = bus.src1;
               dvs_d   = bus.src2;
               rem_d   = '0;
               dbz_d   = 1'b0;
               cnt_d   = CW'(STEPS - 1);
`ifdef DIVN_SIGNED_EN
               // A zero divisor keeps the raw dividend so it can be returned as the remainder.
               if (neg1 && bus.src2 != '0) dvd_d = -bus.src1;
               if (neg2)                   dvs_d = -bus.src2;
               qneg_d  = neg1 ^ neg2;
               rneg_d  = neg1;
`endif
               state_d = (bus.src2 == '0) ? S_FIX : S_CALC;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            rem_d = step_rem;
            dvd_d = step_dvd;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = S_FIX;
         end
         S_FIX: begin
            if (dvs_q == '0) begin
               qut_d = '1;
               rmd_d = dvd_q;
               dbz_d = 1'b1;
            end else begin
               qut_d = dvd_q;
               rmd_d = rem_q;
`ifdef DIVN_SIGNED_EN
               if (qneg_q) qut_d = -dvd_q;
               if (rneg_q) rmd_d = -rem_q;
`endif
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register state and datapath; reset abandons any operation and clears results.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         qut_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef DIVN_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         qut_q   <= qut_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
         cnt_q   <= cnt_d;
`ifdef DIVN_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign bus.qut  = qut_q;
   assign bus.rmd  = rmd_q;
   assign bus.dbz  = dbz_q;
   assign bus.busy = (state_q == S_CALC) || (state_q == S_FIX);
   assign bus.done = (state_q == S_DONE);
endmodule

// File: doc/divn_restoring.md
Name: divn_restoring

Overview:
- Parametrised multi-cycle restoring divider; next generation of the fixed 32-bit unsigned divider.
- Adds configurable operand width, configurable quotient bits retired per cycle, a busy output and an explicit divide-by-zero flag.
- Optional signed mode is compiled in by macro.
- Sits beside the other arithmetic units and is driven by a simple start/done handshake from a controller or testbench.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- SPC, 1, quotient bits resolved per CALC cycle; legal values are 1, 2 and 4; must divide WIDTH evenly.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sgn  input  1  signed-operation request; honoured only with DIVN_SIGNED_EN.
- src1  input  WIDTH  dividend; sampled on the accept edge.
- src2  input  WIDTH  divisor; sampled on the accept edge.
- qut  output  WIDTH  quotient.
- rmd  output  WIDTH  remainder.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle result-valid pulse.
- dbz  output  1  divide-by-zero flag; valid with done.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: qut=0, rmd=0, busy=0, done=0, dbz=0, state=IDLE.
- Reset mid-operation: abandon the operation, clear all outputs, return to IDLE. No done is issued.
- States:
  - IDLE → CALC when start=1 and src2≠0.
  - IDLE → FIX when start=1 and src2=0.
  - CALC → CALC while iteration counter ≠ 0.
  - CALC → FIX on the last iteration.
  - FIX → DONE.
  - DONE → IDLE, or accept a new start in the same cycle (DONE behaves as IDLE for acceptance).
- Accept edge: latch operands, load counter = WIDTH/SPC − 1, clear the partial remainder, set busy=1, clear dbz.
- CALC: each cycle performs SPC restoring steps:
  - Shift in the next dividend MSB.
  - Trial-subtract the divisor; keep the result if non-negative, else restore.
  - Append the quotient bit.
  - Internal remainder path is WIDTH+1 bits.
- FIX: apply the sign correction (signed build only), then drive qut and rmd.
- DONE: done=1 for exactly one cycle; busy=0 in that cycle.
- Results: qut, rmd and dbz hold until the next accept edge.
- Latency:
  - Normal: done is high in the cycle after the (WIDTH/SPC + 2)th rising edge following the accept edge, inclusive of the accept edge. WIDTH=32, SPC=1 → done asserted 34 edges after accept.
  - Divide-by-zero: done 2 edges after accept.
- busy: high from the accept edge until the edge that enters DONE.
- start while busy: ignored; operands are not resampled.
- start held high continuously: back-to-back operations, one accept per DONE cycle.
- Divide by zero (src2=0): qut = all ones, rmd = src1, dbz=1.
- Unsigned arithmetic: qut = floor(src1/src2), rmd = src1 mod src2. Identical to the existing 32-bit unit at WIDTH=32.

Optional Feature:
- Macro: DIVN_SIGNED_EN.
- Defined, and sgn=1 at accept:
  - Operands are two's complement; magnitudes are divided.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / −1 returns qut = MIN, rmd = 0, dbz = 0.
  - Divide by zero returns qut = all ones, rmd = src1.
  - Latency is unchanged; FIX always takes its one cycle.
- Not defined: sgn is ignored, all operations are unsigned, and no sign logic is synthesised.

Test Plan:
- WIDTH=32, SPC=1: src1=100, src2=7 → qut=14, rmd=2, dbz=0, done exactly 34 edges after accept, busy high throughout.
- src1=0x12345678, src2=0 → qut=0xFFFFFFFF, rmd=0x12345678, dbz=1, done 2 edges after accept.
- start pulsed again mid-CALC with src1=9, src2=3 → ignored; first result (100/7) delivered unchanged. Then rst asserted mid-CALC → all outputs 0 next cycle, no done.
- WIDTH=16, SPC=4: src1=0xFFFF, src2=0x0010 → qut=0x0FFF, rmd=0x000F, done 6 edges after accept; sweep 500 random pairs against a reference model.
- DIVN_SIGNED_EN defined, WIDTH=32, sgn=1:
  - −7 / 2 → qut=−3, rmd=−1.
  - 7 / −2 → qut=−3, rmd=1.
  - 0x80000000 / −1 → qut=0x80000000, rmd=0.
- start held high across 3 operations (10/3, 20/6, 5/5) → three done pulses with results 3r1, 3r2, 1r0, each back-to-back from its DONE cycle.
